// File: rtl/rv_wb_decoder.sv
// Wishbone address decoder and response tracker for the core master port.
// Latches one request, routes it by address field, returns ack or err.
module rv_wb_decoder #(
    parameter int N_SLAVES = 4,
    parameter int SEL_HI   = 31,
    parameter int SEL_LO   = 28,
    parameter int TIMEOUT  = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [31:0]           i_wb_adr,
    input  logic [31:0]           i_wb_dat,
    output logic [31:0]           o_wb_dat,
    input  logic                  i_wb_we,
    input  logic [3:0]            i_wb_sel,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_cyc,
    output logic                  o_wb_ack,
    output logic                  o_wb_err,
    output logic [31:0]           o_s_adr,
    output logic [31:0]           o_s_dat,
    output logic                  o_s_we,
    output logic [3:0]            o_s_sel,
    output logic [N_SLAVES-1:0]   o_s_stb,
    output logic [N_SLAVES-1:0]   o_s_cyc,
    input  logic [32*N_SLAVES-1:0] i_s_dat,
    input  logic [N_SLAVES-1:0]   i_s_ack,
    output logic                  o_err_valid,
    output logic [31:0]           o_err_adr,
    input  logic                  i_err_clr
);

    localparam int SW = SEL_HI - SEL_LO + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP,
        ERR
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          sel_ack;
    logic [31:0]   sel_dat;

    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (int'(idx) == k) begin
                sel_ack = i_s_ack[k];
                sel_dat = i_s_dat[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    accept = 1'b1;
                    if (int'(i_wb_adr[SEL_HI:SEL_LO]) < N_SLAVES)
                        state_nx = ACTIVE;
                    else
                        state_nx = ERR;
                end
            end
            ACTIVE: begin
                // An ack in the final allowed cycle beats the timeout.
                if (sel_ack)
                    state_nx = RESP;
                else if (cnt == CW'(TIMEOUT - 1))
                    state_nx = ERR;
            end
            RESP:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            o_s_adr     <= '0;
            o_s_dat     <= '0;
            o_s_we      <= 1'b0;
            o_s_sel     <= '0;
            o_wb_dat    <= '0;
            o_err_valid <= 1'b0;
            o_err_adr   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                o_s_adr <= i_wb_adr;
                o_s_dat <= i_wb_dat;
                o_s_we  <= i_wb_we;
                o_s_sel <= i_wb_sel;
                idx     <= i_wb_adr[SEL_HI:SEL_LO];
                cnt     <= '0;
            end else if (state == ACTIVE && !sel_ack) begin
                cnt <= cnt + CW'(1);
            end
            if (state == ACTIVE && sel_ack)
                o_wb_dat <= sel_dat;
            // A new error outranks a clear in the same cycle.
            if (state_nx == ERR) begin
                o_err_valid <= 1'b1;
                o_err_adr   <= accept ? i_wb_adr : o_s_adr;
            end else if (i_err_clr) begin
                o_err_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        o_s_stb = '0;
        for (int k = 0; k < N_SLAVES; k++)
            o_s_stb[k] = (state == ACTIVE) && (int'(idx) == k);
    end

    assign o_s_cyc  = o_s_stb;
    assign o_wb_ack = (state == RESP);
    assign o_wb_err = (state == ERR);

endmodule

// File: tb/tb_rv_wb_decoder.sv
// Scoreboard bench for rv_wb_decoder with a small wait-state slave model.
// Expected termination kind, latency and data come from the bench model.
module tb_rv_wb_decoder;

    localparam int NS = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   wb_adr, wb_dat, wb_rdat;
    logic          wb_we, wb_stb, wb_cyc, wb_ack, wb_err;
    logic [3:0]    wb_sel;
    logic [31:0]   s_adr, s_dat, err_adr;
    logic          s_we, err_valid, err_clr;
    logic [3:0]    s_sel;
    logic [NS-1:0] s_stb, s_cyc, s_ack, noise;
    logic [32*NS-1:0] s_rdat;

    always #5 clk = ~clk;

    rv_wb_decoder #(
        .N_SLAVES(NS), .SEL_HI(31), .SEL_LO(28), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .o_wb_dat(wb_rdat),
        .i_wb_we(wb_we), .i_wb_sel(wb_sel),
        .i_wb_stb(wb_stb), .i_wb_cyc(wb_cyc),
        .o_wb_ack(wb_ack), .o_wb_err(wb_err),
        .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_we(s_we), .o_s_sel(s_sel),
        .o_s_stb(s_stb), .o_s_cyc(s_cyc),
        .i_s_dat(s_rdat), .i_s_ack(s_ack),
        .o_err_valid(err_valid), .o_err_adr(err_adr),
        .i_err_clr(err_clr)
    );

    typedef struct {
        logic        err;
        logic [31:0] dat;
        logic [31:0] adr;
        int          t_acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          ccount = 0;
    int          stb_cycles = 0;
    int          wcfg[NS];
    int          wcnt[NS];
    logic [31:0] sdat[NS];
    logic [31:0] model_dat;
    logic [31:0] cur_adr, cur_dat;
    logic [3:0]  cur_sel, cur_stb;
    logic        cur_we;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(posedge clk) ccount <= ccount + 1;

    always @(posedge clk)
        for (int k = 0; k < NS; k++)
            wcnt[k] <= s_stb[k] ? wcnt[k] + 1 : 0;

    always_comb begin
        s_ack  = '0;
        s_rdat = '0;
        for (int k = 0; k < NS; k++) begin
            s_ack[k] = (s_stb[k] && wcnt[k] == wcfg[k]) ||
                       (noise[k] && !s_stb[k]);
            s_rdat[32*k +: 32] = sdat[k];
        end
    end

    always @(negedge clk) begin
        if (wb_ack && wb_err)
            check("ack_err_excl", 32'(wb_ack && wb_err), 32'd0);
        if (s_stb != '0) begin
            stb_cycles++;
            check("s_stb", 32'(s_stb), 32'(cur_stb));
            check("s_cyc", 32'(s_cyc), 32'(cur_stb));
            check("s_adr", s_adr, cur_adr);
            check("s_dat", s_dat, cur_dat);
            check("s_sel", 32'(s_sel), 32'(cur_sel));
            check("s_we", 32'(s_we), 32'(cur_we));
        end
        if (wb_ack || wb_err) begin
            if (sb.size() == 0) begin
                check("spurious", 32'({wb_err, wb_ack}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_err", 32'(wb_err), 32'(e.err));
                check("latency", 32'(ccount - e.t_acc + 1), 32'(e.lat));
                check("rdat", wb_rdat, e.dat);
                if (e.err) begin
                    check("err_valid", 32'(err_valid), 32'd1);
                    check("err_adr", err_adr, e.adr);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] adr, input logic [31:0] dat,
                          input logic we, input logic [3:0] sel,
                          input logic clr);
        exp_t x;
        int   idx;
        @(negedge clk);
        idx     = int'(adr[31:28]);
        cur_adr = adr;
        cur_dat = dat;
        cur_we  = we;
        cur_sel = sel;
        cur_stb = (idx < NS) ? 4'(1 << idx) : 4'd0;
        x.adr   = adr;
        if (idx >= NS) begin
            x.err = 1'b1;
            x.lat = 1;
        end else if (wcfg[idx] < TO) begin
            x.err     = 1'b0;
            x.lat     = 2 + wcfg[idx];
            model_dat = sdat[idx];
        end else begin
            x.err = 1'b1;
            x.lat = TO + 1;
        end
        x.dat      = model_dat;
        x.t_acc    = ccount + 1;
        stb_cycles = 0;
        sb.push_back(x);
        wb_adr  = adr;
        wb_dat  = dat;
        wb_we   = we;
        wb_sel  = sel;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        err_clr = clr;
        @(posedge clk);
        #1;
        wb_cyc  = 1'b0;
        wb_stb  = 1'b0;
        err_clr = 1'b0;
        wb_adr  = $urandom;
        wb_dat  = $urandom;
        wb_sel  = 4'($urandom);
        wb_we   = ~we;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        check("stb_cycles", 32'(stb_cycles),
              32'((cur_stb == 0) ? 0 : x.lat - 1));
    endtask

    initial begin
        rst_n = 1'b0;
        wb_adr = '0; wb_dat = '0; wb_we = 1'b0; wb_sel = '0;
        wb_stb = 1'b0; wb_cyc = 1'b0; err_clr = 1'b0; noise = '0;
        cur_adr = '0; cur_dat = '0; cur_we = 1'b0;
        cur_sel = '0; cur_stb = '0;
        model_dat = '0;
        for (int k = 0; k < NS; k++) begin
            wcfg[k] = 0;
            wcnt[k] = 0;
            sdat[k] = 32'hA000_0000 + 32'(k);
        end
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(s_stb), 32'd0);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_err", 32'(wb_err), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_rdat", wb_rdat, 32'd0);
        check("rst_s_adr", s_adr, 32'd0);
        check("rst_err_adr", err_adr, 32'd0);
        rst_n = 1'b1;

        sdat[1] = 32'hDEAD_BEEF;
        do_req(32'h1000_0010, 32'h0, 1'b0, 4'hF, 1'b0);
        check("no_err_valid", 32'(err_valid), 32'd0);

        wcfg[2] = 3;
        sdat[2] = 32'hCAFE_0002;
        do_req(32'h2000_0004, 32'h1234_5678, 1'b1, 4'b0011, 1'b0);

        do_req(32'h5000_0000, 32'h0, 1'b0, 4'hF, 1'b0);

        wcfg[0] = 100;
        noise   = 4'b1110;
        do_req(32'h0000_0100, 32'h55AA_55AA, 1'b1, 4'b1000, 1'b0);
        noise   = '0;
        wcfg[0] = TO - 1;
        sdat[0] = 32'h0BAD_F00D;
        do_req(32'h0000_0104, 32'h0, 1'b0, 4'hF, 1'b0);

        @(negedge clk);
        check("err_valid_pre", 32'(err_valid), 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_alone", 32'(err_valid), 32'd0);

        do_req(32'hF000_0008, 32'h0, 1'b0, 4'hF, 1'b1);
        @(negedge clk);
        check("set_beats_clr", 32'(err_valid), 32'd1);

        wcfg[0] = 100;
        @(negedge clk);
        cur_adr = 32'h0000_0040; cur_dat = 32'h7;
        cur_we = 1'b1; cur_sel = 4'h1; cur_stb = 4'b0001;
        wb_adr = cur_adr; wb_dat = cur_dat; wb_we = 1'b1; wb_sel = 4'h1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk);
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_stb", 32'(s_stb), 32'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_stb", 32'(s_stb), 32'd0);
        check("async_cyc", 32'(s_cyc), 32'd0);
        model_dat = '0;
        repeat (2) @(negedge clk);
        check("rst_no_ack", 32'({wb_ack, wb_err}), 32'd0);
        rst_n = 1'b1;

        wcfg[3] = 1;
        sdat[3] = 32'h3333_0003;
        do_req(32'h3000_0000, 32'h0, 1'b0, 4'hF, 1'b0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_wb_decoder.md
# rv_wb_decoder

Wishbone address decoder and response tracker sitting directly downstream of the core's Wishbone master port. It accepts each single-beat request from the core, latches it, routes it to one of `N_SLAVES` peripheral slaves by address field, and returns one `o_wb_ack` pulse with registered read data. Unmapped addresses and slaves that never respond terminate with a one-cycle `o_wb_err` pulse. The faulting address is captured for software diagnosis.

## Interface
- `N_SLAVES`, default 4: number of slave ports, 1..16.
- `SEL_HI`, default 31: MSB of the slave-select address field.
- `SEL_LO`, default 28: LSB of the slave-select field. Field width is SEL_HI-SEL_LO+1 and must satisfy 2^width >= N_SLAVES.
- `TIMEOUT`, default 255: ACTIVE cycles without ack before error, >= 1.
- `i_clk` in 1: clock, rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_wb_adr` in 32: master address.
- `i_wb_dat` in 32: master write data.
- `o_wb_dat` out 32: read data returned to master.
- `i_wb_we` in 1: write enable.
- `i_wb_sel` in 4: byte lanes.
- `i_wb_stb` in 1: strobe.
- `i_wb_cyc` in 1: cycle.
- `o_wb_ack` out 1: normal termination pulse.
- `o_wb_err` out 1: error termination pulse.
- `o_s_adr` out 32: latched address, shared by all slaves.
- `o_s_dat` out 32: latched write data, shared.
- `o_s_we` out 1: latched we, shared.
- `o_s_sel` out 4: latched sel, shared.
- `o_s_stb` out N_SLAVES: one-hot strobe.
- `o_s_cyc` out N_SLAVES: one-hot cycle, equal to `o_s_stb`.
- `i_s_dat` in 32*N_SLAVES: slave read data; slave k occupies bits [32k+31:32k].
- `i_s_ack` in N_SLAVES: slave acks.
- `o_err_valid` out 1: sticky error flag.
- `o_err_adr` out 32: address of the most recent errored request.
- `i_err_clr` in 1: clears `o_err_valid`.

## Operation
- FSM states: IDLE, ACTIVE, RESP, ERR.
- IDLE:
  - A request is accepted when `i_wb_cyc & i_wb_stb`.
  - On acceptance, latch adr/dat/we/sel into the `o_s_*` registers and latch idx = adr[SEL_HI:SEL_LO].
  - If idx < N_SLAVES, go to ACTIVE. Otherwise go to ERR.
- After acceptance, master `cyc`/`stb` are ignored until the block returns to IDLE. The request is latched, so a single-cycle strobe is sufficient.
- ACTIVE:
  - `o_s_stb[idx]` and `o_s_cyc[idx]` are 1; all other bits are 0.
  - Timeout counter starts at 0 on entry and increments each ACTIVE cycle in which `i_s_ack[idx]` is 0.
  - If `i_s_ack[idx]` is 1: capture `i_s_dat` slice idx into `o_wb_dat` and go to RESP. This is done for writes too.
  - Else if counter == TIMEOUT-1: go to ERR.
  - Acks from non-selected slaves are ignored.
- RESP: `o_wb_ack`=1 for exactly one cycle, then IDLE. A request present during RESP is not accepted.
- ERR:
  - `o_wb_err`=1 for exactly one cycle, then IDLE.
  - Set `o_err_valid` and load `o_err_adr` with the latched address.
  - `o_wb_dat` is unchanged.
- `o_wb_ack` and `o_wb_err` are never high in the same cycle.
- `i_err_clr` clears `o_err_valid` on the next edge. If an ERR-entry set happens in the same cycle, the set wins.
- Counter width is $clog2(TIMEOUT+1). The counter does not wrap within a transaction.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - State returns to IDLE.
  - `o_s_stb`, `o_s_cyc`, `o_wb_ack`, `o_wb_err`, `o_err_valid` = 0.
  - `o_wb_dat`, `o_s_adr`, `o_s_dat`, `o_err_adr` = 0; `o_s_we` = 0; `o_s_sel` = 0.
  - Counter = 0.
  - Reset in any state aborts the transaction with no ack or err.
- Request accepted at edge T:
  - `o_s_stb` high from T+1.
  - A slave that acks combinationally in the first ACTIVE cycle produces `o_wb_ack` in cycle T+2. This is the minimum latency of 2.
- Slave ack after k wait cycles: `o_wb_ack` at T+2+k.
- Unmapped address: `o_wb_err` during T+1. IDLE again at T+2, and the next request can be accepted at T+2.
- Timeout:
  - ACTIVE spans T+1..T+TIMEOUT and `o_wb_err` is asserted in cycle T+TIMEOUT+1.
  - An ack arriving in the last ACTIVE cycle (counter == TIMEOUT-1) wins: the result is RESP, not ERR.
- Back-to-back requests: the next accept occurs at the earliest in the cycle following RESP/ERR. There is one IDLE cycle minimum between transactions.

## Test plan
- Read from slave 1: adr=0x1000_0010, slave 1 acks in the same cycle with 0xDEAD_BEEF. Required: `o_s_stb`=4'b0010 for 1 cycle; `o_wb_ack` at T+2 with `o_wb_dat`=0xDEAD_BEEF; `o_err_valid`=0.
- Write to slave 2 with 3 wait states: adr=0x2000_0004, dat=0x1234_5678, sel=4'b0011. Required: `o_s_dat`/`o_s_sel` held for 4 ACTIVE cycles; `o_wb_ack` at T+5.
- Unmapped address: adr=0x5000_0000 with N_SLAVES=4. Required: `o_s_stb` stays 0; `o_wb_err` at T+1; `o_err_adr`=0x5000_0000; `o_err_valid`=1.
- Timeout with TIMEOUT=8 and slave 0 silent. Required: `o_wb_err` at T+9. Repeat with the ack in the 8th ACTIVE cycle: `o_wb_ack` and no err.
- `i_err_clr` asserted in the same cycle as a new ERR entry: `o_err_valid` remains 1. Clear alone: `o_err_valid`=0 on the next edge.
- Assert `i_reset_n`=0 mid-ACTIVE. Required: all strobes drop immediately (asynchronous); no ack/err; the first request after release completes normally.
